// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame width and
// line-level constants, common to the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4,
    PARITY = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// CPU-side view of the receiver holding register. parity_err exists only
// when UART_RX_PARITY_EN is defined.
interface uart_rx_if import uart_pkg::*; #(
  parameter int DATA_BITS = UART_DATA_BITS
) ();

  logic                 read_ack;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 framing_err;
  logic                 overrun;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    input  read_ack,
    output data, valid, framing_err, overrun, busy
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );

  modport slave (
    output read_ack,
    input  data, valid, framing_err, overrun, busy
`ifdef UART_RX_PARITY_EN
    , input parity_err
`endif
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle
// (high) line level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments keep meta and q as two distinct stages;
  // blocking ones here would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a one-deep holding register. OVERSAMPLE
// must be even and >= 4. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx import uart_pkg::*; #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sample_tick,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_STOP   = STOP;
  localparam logic [2:0] S_BREAK  = BREAK;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
`endif

  logic                 rx_s;
  logic [2:0]           state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 load;
  logic                 ack;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign load     = sample_tick && (state == S_STOP) && (tick_cnt == TICK_END);
  assign ack      = bus.read_ack && bus.valid;
  assign bus.busy = (state != S_IDLE);

  // Frame sequencer; every transition waits for a sample tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (sample_tick) begin
      tick_cnt <= (tick_cnt == TICK_END) ? '0 : tick_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (rx_s == START_BIT) begin
            state    <= S_START;
            tick_cnt <= '0;
          end
        end
        S_START: begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= (rx_s == START_BIT) ? S_DATA : S_IDLE;
          end
        end
        S_DATA: begin
          if (tick_cnt == TICK_END) begin
            tick_cnt <= '0;
            shift    <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_cnt == TICK_END) begin
            tick_cnt   <= '0;
            parity_bit <= rx_s;
            state      <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick_cnt == TICK_END) begin
            tick_cnt <= '0;
            state    <= (rx_s == STOP_BIT) ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          // A line held low after a bad stop bit must not restart a frame.
          if (rx_s == STOP_BIT) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Holding register: a load always wins over a coincident read_ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.data        <= '0;
      bus.valid       <= 1'b0;
      bus.framing_err <= 1'b0;
      bus.overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_err  <= 1'b0;
`endif
    end else if (load) begin
      bus.data        <= shift;
      bus.valid       <= 1'b1;
      bus.framing_err <= (rx_s != STOP_BIT);
`ifdef UART_RX_PARITY_EN
      bus.parity_err  <= parity_bit ^ (^shift);
`endif
      if (bus.valid && !bus.read_ack) bus.overrun <= 1'b1;
      else if (ack)                   bus.overrun <= 1'b0;
    end else if (ack) begin
      bus.valid   <= 1'b0;
      bus.overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// compared against a frame-level model of the holding register.
module tb_uart_rx;

  localparam int OS        = 16;
  localparam int DB        = 8;
  localparam int TICK_DIV  = 4;
  localparam int BIT_CLKS  = TICK_DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Edge (relative to the first start-bit edge) on which the byte is loaded:
  // one tick to spot the start bit, half a bit to its middle, then whole bits.
  localparam int LOAD_EDGE = TICK_DIV * (1 + OS / 2 + OS * (DB + PAR + 1));

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       sample_tick;
  logic [1:0] tdiv = 2'd0;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_data;
  logic       m_valid, m_fe, m_ovr, m_pe;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .rx          (rx),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign sample_tick = (tdiv == 2'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---- reference model of the holding register ----
  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ovr = 1'b0; m_pe = 1'b0;
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [7:0] value, input logic stop,
                             input logic par_bad, input logic ack_same_cycle);
    if (m_valid) m_ovr = !ack_same_cycle;
    m_data  = value;
    m_valid = 1'b1;
    m_fe    = !stop;
    m_pe    = (PAR != 0) && par_bad;
  endtask

  task automatic check_all(input string tag, input logic exp_busy);
    check({tag, ".data"},        32'(bus.data),        32'(m_data));
    check({tag, ".valid"},       32'(bus.valid),       32'(m_valid));
    check({tag, ".framing_err"}, 32'(bus.framing_err), 32'(m_fe));
    check({tag, ".overrun"},     32'(bus.overrun),     32'(m_ovr));
`ifdef UART_RX_PARITY_EN
    check({tag, ".parity_err"},  32'(bus.parity_err),  32'(m_pe));
`endif
    check({tag, ".busy"},        32'(bus.busy),        32'(exp_busy));
  endtask

  // ---- stimulus helpers; all start and end at a negedge ----
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    bus.read_ack = 1'b1;
    @(negedge clk);
    bus.read_ack = 1'b0;
    model_ack();
  endtask

  // Wait until the next posedge is a sample-tick edge (bounded).
  task automatic align_tick();
    int n = 0;
    while (!sample_tick && n < 2 * TICK_DIV) begin
      @(negedge clk);
      n++;
    end
    check("tick_align", 32'(sample_tick), 32'd1);
  endtask

  // Drives one frame, then hold_low extra low bit times. ack_edge / rst_edge
  // (-1 = none) pulse read_ack / rst_n on that edge; a reset aborts the frame.
  task automatic send_frame(input logic [7:0] value, input logic stop, input logic par_bad,
                            input int ack_edge, input int rst_edge, input int hold_low);
    logic [11:0] fbits;
    int nbits;
    fbits    = '1;
    fbits[0] = 1'b0;
    for (int i = 0; i < DB; i++) fbits[1+i] = value[i];
`ifdef UART_RX_PARITY_EN
    fbits[DB+1] = (^value) ^ par_bad;
`endif
    fbits[DB+1+PAR] = stop;
    nbits = DB + 2 + PAR;
    align_tick();
    for (int e = 0; e < (nbits + hold_low) * BIT_CLKS; e++) begin
      rx           = (e < nbits * BIT_CLKS) ? fbits[e / BIT_CLKS] : 1'b0;
      bus.read_ack = (e == ack_edge);
      rst_n        = (e != rst_edge);
      @(negedge clk);
      if (e == rst_edge) begin
        rx = 1'b1;
        break;
      end
    end
    bus.read_ack = 1'b0;
    rst_n        = 1'b1;
  endtask

  initial begin
    logic [7:0] val;
    logic       stop, pb, ackc;

    rst_n = 1'b0;
    rx = 1'b1;
    bus.read_ack = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_all("reset", 1'b0);
    rst_n = 1'b1;
    idle(20);

    // Clean frame, then consumer read.
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1, 0);
    model_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_all("a5", 1'b0);
    pulse_ack();
    check("a5_ack.valid", 32'(bus.valid), 32'd0);
    idle(40);

    // Short low glitch: start bit rejected at its middle.
    align_tick();
    for (int e = 0; e < 40; e++) begin
      rx = (e < 4 * TICK_DIV) ? 1'b0 : 1'b1;
      if (e == 20) check("glitch_mid.busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    check_all("glitch", 1'b0);
    idle(40);

    // Bad stop bit with the line held low well beyond a frame length.
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1, 11);
    model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_all("break_low", 1'b1);
    idle(2 * BIT_CLKS);
    check_all("break_release", 1'b0);
    pulse_ack();
    send_frame(8'h11, 1'b1, 1'b0, -1, -1, 0);
    model_frame(8'h11, 1'b1, 1'b0, 1'b0);
    check_all("after_break", 1'b0);
    pulse_ack();
    idle(40);

    // Overrun: two bytes without a read.
    send_frame(8'h01, 1'b1, 1'b0, -1, -1, 0);
    model_frame(8'h01, 1'b1, 1'b0, 1'b0);
    idle(40);
    send_frame(8'h02, 1'b1, 1'b0, -1, -1, 0);
    model_frame(8'h02, 1'b1, 1'b0, 1'b0);
    check_all("overrun", 1'b0);
    pulse_ack();
    check_all("overrun_ack", 1'b0);
    idle(40);

    // read_ack on the exact load edge of the second byte.
    send_frame(8'h5A, 1'b1, 1'b0, -1, -1, 0);
    model_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    idle(40);
    send_frame(8'h7E, 1'b1, 1'b0, LOAD_EDGE, -1, 0);
    model_frame(8'h7E, 1'b1, 1'b0, 1'b1);
    check_all("ack_on_load", 1'b0);
    idle(40);

    // Reset in the middle of data bit 4.
    send_frame(8'h55, 1'b1, 1'b0, -1, 5 * BIT_CLKS + BIT_CLKS / 2, 0);
    model_reset();
    check_all("mid_reset", 1'b0);
    idle(2 * BIT_CLKS);
    send_frame(8'hC3, 1'b1, 1'b0, -1, -1, 0);
    model_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    check_all("c3", 1'b0);
`ifdef UART_RX_PARITY_EN
    pulse_ack();
    idle(40);
    send_frame(8'hC3, 1'b1, 1'b1, -1, -1, 0);
    model_frame(8'hC3, 1'b1, 1'b1, 1'b0);
    check_all("c3_bad_parity", 1'b0);
`endif
    idle(40);

    // Random frames: random data, occasional bad stop/parity, random reads.
    for (int k = 0; k < 8; k++) begin
      val  = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      pb   = (PAR != 0) && ($urandom_range(0, 3) == 0);
      ackc = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) pulse_ack();
      send_frame(val, stop, pb, ackc ? LOAD_EDGE : -1, -1, 0);
      model_frame(val, stop, pb, ackc);
      idle(2 * BIT_CLKS);
      check_all($sformatf("rand%0d", k), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
